meter_peak_accum: RTL and testbench

- Sits between dsp_core's aux output (aux_out_addr/data/en) and the SPI memif meter read path.
- Replaces the plain meter_mem write path with a per-channel peak-magnitude accumulator.
- Each DSP aux write folds |sample| into the stored peak for that address.
- The host reads peaks through a req/ack port with optional clear-on-read, so each read reports the peak since the previous read.

---
 rtl/meter_pkg.sv | 36 +++
 rtl/meter_peak_ram.sv | 27 ++
 rtl/meter_peak_accum.sv | 133 +++++++++++++
 tb/tb_meter_peak_accum.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared types and helpers for the meter peak accumulator.
//   peak_t  : stored peak word (unsigned magnitude, MSB always 0)
//   state_e : sweep-clear / running
//   op_e    : operation carried through the two-stage pipeline
//   sat_abs : saturating absolute value of a sign-extended sample
package meter_pkg;

   // Widest sample the helpers handle; DATA_WIDTH must not exceed this.
   localparam int PEAK_W = 36;

   typedef logic [PEAK_W-1:0] peak_t;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_DSP  = 2'd1,
      OP_HOST = 2'd2
   } op_e;

   // x is a w-bit sample sign-extended to PEAK_W. The most-negative w-bit
   // value has no positive counterpart, so the result is clamped to the
   // largest positive w-bit value, which also keeps bit w-1 clear.
   function automatic peak_t sat_abs(input peak_t x, input int unsigned w);
      peak_t m;
      peak_t lim;
      lim = (peak_t'(1) << (w - 1)) - peak_t'(1);
      m   = x[PEAK_W-1] ? (~x + peak_t'(1)) : x;
      if (m > lim) m = lim;
      return m;
   endfunction

endpackage

// File: rtl/meter_peak_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
// No reset on the array or read register so it maps onto block RAM.
//   dsp_clk            : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_addr            : read address, sampled every cycle
//   rd_data            : registered read data, 1-cycle latency
module meter_peak_ram #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  dsp_clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge dsp_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/meter_peak_accum.sv
// Per-channel peak-magnitude accumulator between the DSP aux output and the
// host meter read path. Each aux write folds |sample| into the stored peak;
// host reads return the peak and optionally clear it.
//   dsp_clk, reset_n              : clock, async active-low reset
//   aux_en/aux_addr/aux_data      : DSP update strobe, slot, signed sample
//   host_rd_req/host_rd_addr      : host read request (held until ack)
//   host_rd_ack                   : request accepted this cycle
//   host_rd_valid/host_rd_data    : read result, one cycle after ack
//   clear_req                     : zero every slot (sweep)
//   busy                          : sweep-clear in progress
module meter_peak_accum
   import meter_pkg::*;
#(
   parameter int DATA_WIDTH    = 36,
   parameter int ADDR_WIDTH    = 8,
   parameter bit CLEAR_ON_READ = 1'b1
) (
   input  logic                  dsp_clk,
   input  logic                  reset_n,
   input  logic                  aux_en,
   input  logic [ADDR_WIDTH-1:0] aux_addr,
   input  logic [DATA_WIDTH-1:0] aux_data,
   input  logic                  host_rd_req,
   input  logic [ADDR_WIDTH-1:0] host_rd_addr,
   output logic                  host_rd_ack,
   output logic                  host_rd_valid,
   output logic [DATA_WIDTH-1:0] host_rd_data,
   input  logic                  clear_req,
   output logic                  busy
);

   typedef struct packed {
      op_e                   op;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] mag;
   } stage_t;

   state_e                state;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic                  run;

   stage_t                s1, s2;
   logic [DATA_WIDTH-1:0] ram_q, old_val, s2_wdata;
   logic                  s2_we;

   logic                  fwd_vld;
   logic [ADDR_WIDTH-1:0] fwd_addr;
   logic [DATA_WIDTH-1:0] fwd_data;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;

   assign run  = (state == RUN);
   assign busy = (state == CLEAR);

   // Sweep FSM: one slot zeroed per cycle; clear_req always restarts at 0.
   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
      end else if (clear_req) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
      end else if (state == CLEAR) begin
         if (sweep_cnt == '1) state <= RUN;
         sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
      end
   end

   // S1 issue: DSP updates win the slot, the host only gets idle cycles.
   assign host_rd_ack = host_rd_req & ~aux_en & run;

   always_comb begin
      s1      = '0;
      s1.op   = OP_NONE;
      s1.addr = aux_en ? aux_addr : host_rd_addr;
      s1.mag  = DATA_WIDTH'(sat_abs(peak_t'($signed(aux_data)), DATA_WIDTH));
      if (aux_en && run) s1.op = OP_DSP;
      else if (host_rd_ack) s1.op = OP_HOST;
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         s2    <= '0;
         s2.op <= OP_NONE;
      end else begin
         s2 <= s1;
      end
   end

   // S2 resolve. The RAM returns old data when the previous op writes the
   // same slot on the same edge, so that write is bypassed from fwd_*.
   assign old_val = (fwd_vld && fwd_addr == s2.addr) ? fwd_data : ram_q;

   // Only commit while running: an op that lands in S2 after a clear
   // starts is flushed (its read result is still reported).
   assign s2_we    = run && (s2.op == OP_DSP || (s2.op == OP_HOST && CLEAR_ON_READ));
   assign s2_wdata = (s2.op == OP_DSP) ? ((old_val > s2.mag) ? old_val : s2.mag) : '0;

   assign host_rd_valid = (s2.op == OP_HOST);
   assign host_rd_data  = host_rd_valid ? old_val : '0;

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_vld  <= 1'b0;
         fwd_addr <= '0;
         fwd_data <= '0;
      end else begin
         fwd_vld  <= s2_we;
         fwd_addr <= s2.addr;
         fwd_data <= s2_wdata;
      end
   end

   // Sweep and pipeline never write in the same cycle (s2_we needs RUN).
   assign ram_we    = busy | s2_we;
   assign ram_waddr = busy ? sweep_cnt : s2.addr;
   assign ram_wdata = busy ? '0 : s2_wdata;

   meter_peak_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .dsp_clk (dsp_clk),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr (s1.addr),
      .rd_data (ram_q)
   );

endmodule

// File: tb/tb_meter_peak_accum.sv
module tb_meter_peak_accum;

   localparam int DW = 36;
   localparam int AW = 8;
   localparam int DEPTH = 1 << AW;

   logic          dsp_clk = 1'b0;
   logic          reset_n;
   logic          aux_en;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_data;
   logic          host_rd_req;
   logic [AW-1:0] host_rd_addr;
   logic          host_rd_ack;
   logic          host_rd_valid;
   logic [DW-1:0] host_rd_data;
   logic          clear_req;
   logic          busy;

   meter_peak_accum #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_READ(1'b1)) dut (
      .dsp_clk       (dsp_clk),
      .reset_n       (reset_n),
      .aux_en        (aux_en),
      .aux_addr      (aux_addr),
      .aux_data      (aux_data),
      .host_rd_req   (host_rd_req),
      .host_rd_addr  (host_rd_addr),
      .host_rd_ack   (host_rd_ack),
      .host_rd_valid (host_rd_valid),
      .host_rd_data  (host_rd_data),
      .clear_req     (clear_req),
      .busy          (busy)
   );

   always #5 dsp_clk = ~dsp_clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] sb [$];
   logic          pend = 1'b0;
   logic          last_ack = 1'b0;
   logic [DW-1:0] last_rd = '0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] d0, d1, d2;
      logic [DW-1:0] peak;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_abs(input logic [DW-1:0] d);
      if (d == 36'h8_0000_0000) return 36'h7_FFFF_FFFF;
      return d[DW-1] ? (36'd0 - d) : d;
   endfunction

   // One clock cycle: sample everything at the falling edge, update the
   // reference model in issue order, then return just after the next rise.
   task automatic tick();
      logic [DW-1:0] e;
      @(negedge dsp_clk);
      last_ack = 1'b0;
      if (reset_n) begin
         if (host_rd_valid) begin
            chk("valid_without_ack", 64'(pend), 64'd1);
            if (sb.size() == 0) begin
               chk("valid_sb_empty", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               chk("rd_data", 64'(host_rd_data), 64'(e));
            end
            last_rd = host_rd_data;
         end else if (pend) begin
            chk("valid_missing", 64'(host_rd_valid), 64'd1);
         end
         if (host_rd_ack && (aux_en || busy)) chk("ack_blocked", 64'(host_rd_ack), 64'd0);
         pend     = host_rd_ack;
         last_ack = host_rd_ack;
         if (aux_en && !busy) begin
            if (ref_abs(aux_data) > model[aux_addr]) model[aux_addr] = ref_abs(aux_data);
         end else if (host_rd_ack) begin
            sb.push_back(model[host_rd_addr]);
            model[host_rd_addr] = '0;
         end
         if (clear_req) foreach (model[i]) model[i] = '0;
      end
      @(posedge dsp_clk);
      #1;
   endtask

   task automatic host_read(input logic [AW-1:0] a);
      int n = 0;
      host_rd_req  = 1'b1;
      host_rd_addr = a;
      do begin
         tick();
         n++;
      end while (!last_ack && n < 50);
      if (!last_ack) chk("ack_timeout", 64'd0, 64'd1);
      host_rd_req = 1'b0;
      tick();
   endtask

   task automatic aux_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      aux_en = 1'b1; aux_addr = a; aux_data = d;
      tick();
      aux_en = 1'b0;
   endtask

   initial begin
      int n;
      reset_n = 1'b0; aux_en = 1'b0; aux_addr = '0; aux_data = '0;
      host_rd_req = 1'b0; host_rd_addr = '0; clear_req = 1'b0;
      foreach (model[i]) model[i] = '0;

      vecs[0] = '{8'd5,  36'd100,           -36'sd300, 36'd200, 36'd300};
      vecs[1] = '{8'd7,  36'h8_0000_0000,   36'd0,     36'd0,   36'h7_FFFF_FFFF};
      vecs[2] = '{8'd10, 36'h7_FFFF_FFFF,   -36'sd1,   36'd5,   36'h7_FFFF_FFFF};
      vecs[3] = '{8'd11, -36'sd1,           36'd0,     36'd0,   36'd1};
      vecs[4] = '{8'd12, 36'd0,             36'd0,     36'd0,   36'd0};
      vecs[5] = '{8'd13, 36'd3,             36'd2,     36'd1,   36'd3};
      vecs[6] = '{8'd14, -36'sd5,           -36'sd6,   -36'sd7, 36'd7};

      // Reset state
      #12;
      chk("reset_busy", 64'(busy), 64'd1);
      chk("reset_valid", 64'(host_rd_valid), 64'd0);
      chk("reset_data", 64'(host_rd_data), 64'd0);
      @(posedge dsp_clk); #1;
      reset_n = 1'b1;

      // Sweep after reset lasts exactly DEPTH cycles
      n = 0;
      while (busy && n < 400) begin n++; tick(); end
      chk("reset_sweep_cycles", 64'(n), 64'(DEPTH));
      host_read(8'd0);   chk("post_reset_rd0", 64'(last_rd), 64'd0);
      host_read(8'd128); chk("post_reset_rd128", 64'(last_rd), 64'd0);
      host_read(8'd255); chk("post_reset_rd255", 64'(last_rd), 64'd0);

      // Table: three back-to-back updates, immediate read, then re-read
      for (int i = 0; i < 7; i++) begin
         aux_en = 1'b1; aux_addr = vecs[i].addr;
         aux_data = vecs[i].d0; tick();
         aux_data = vecs[i].d1; tick();
         aux_data = vecs[i].d2; tick();
         aux_en = 1'b0;
         host_read(vecs[i].addr);
         chk($sformatf("vec%0d_peak", i), 64'(last_rd), 64'(vecs[i].peak));
         host_read(vecs[i].addr);
         chk($sformatf("vec%0d_cleared", i), 64'(last_rd), 64'd0);
      end

      // Sustained aux_en starves the host
      host_rd_req = 1'b1; host_rd_addr = 8'd20;
      aux_en = 1'b1; aux_addr = 8'd21;
      for (int i = 0; i < 10; i++) begin
         aux_data = 36'(i * 10 + 1);
         tick();
         chk("starve_no_ack", 64'(last_ack), 64'd0);
      end
      aux_en = 1'b0;
      tick();
      chk("starve_ack_on_drop", 64'(last_ack), 64'd1);
      host_rd_req = 1'b0;
      tick();
      chk("starve_valid_next", 64'(pend || host_rd_valid), 64'd0);
      host_read(8'd21);
      chk("starve_peak21", 64'(last_rd), 64'd91);

      // Read then immediate update of the same slot: forwarding after clear
      aux_wr(8'd9, 36'd50);
      tick(); tick();
      host_rd_req = 1'b1; host_rd_addr = 8'd9;
      tick();
      chk("fwd_ack", 64'(last_ack), 64'd1);
      host_rd_req = 1'b0;
      aux_en = 1'b1; aux_addr = 8'd9; aux_data = -36'sd80;
      tick();
      aux_en = 1'b0;
      chk("fwd_read_old", 64'(last_rd), 64'd50);
      host_read(8'd9);
      chk("fwd_after_clear", 64'(last_rd), 64'd80);

      // Random mixed traffic on a few slots, checked by the scoreboard
      for (int i = 0; i < 300; i++) begin
         aux_en   = 1'($urandom_range(0, 1));
         aux_addr = 8'($urandom_range(0, 7));
         aux_data = 36'({$urandom(), $urandom()});
         if (!host_rd_req && $urandom_range(0, 2) == 0) begin
            host_rd_req  = 1'b1;
            host_rd_addr = 8'($urandom_range(0, 7));
         end
         tick();
         if (last_ack) host_rd_req = 1'b0;
      end
      aux_en = 1'b0;
      n = 0;
      while (host_rd_req && n < 20) begin n++; tick(); if (last_ack) host_rd_req = 1'b0; end
      tick(); tick();

      // Clear mid-stream with every slot loaded
      aux_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         aux_addr = 8'(i); aux_data = 36'(i + 1); tick();
      end
      aux_addr = 8'd3; aux_data = 36'd999; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      host_rd_req = 1'b1; host_rd_addr = 8'd200;
      n = 0;
      while (busy && n < 400) begin
         n++;
         aux_addr = 8'($urandom_range(0, 255));
         aux_data = 36'h1_0000_0000;
         tick();
      end
      chk("clear_sweep_cycles", 64'(n), 64'(DEPTH));
      aux_en = 1'b0;
      tick();
      chk("clear_ack_after", 64'(last_ack), 64'd1);
      host_rd_req = 1'b0;
      tick();
      chk("clear_rd200", 64'(last_rd), 64'd0);
      host_read(8'd0);   chk("clear_rd0", 64'(last_rd), 64'd0);
      host_read(8'd3);   chk("clear_rd3", 64'(last_rd), 64'd0);
      host_read(8'd100); chk("clear_rd100", 64'(last_rd), 64'd0);
      host_read(8'd255); chk("clear_rd255", 64'(last_rd), 64'd0);

      tick(); tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
